bitslam_reg_writer: RTL and testbench

- Host-side writer for the bitslam register bus: the 7 bus bits that sit above the clock bit.
- The bus is `bus_sel` plus the 6-bit `bus_addr_data`.
  - `bus_sel=0` writes the address latch from `bus_addr_data[1:0]`, encoded as {voice, reg}.
  - `bus_sel=1` writes `bus_addr_data` into the addressed voice register. The chip does this on every clock edge while `bus_sel=1`.
- The block queues register-write requests in a small FIFO. It serialises each request into an address phase followed by exactly one data phase.
- It sits between the test/control logic and the sound chip, on the same `clk`.

---
 rtl/bitslam_reg_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_bitslam_reg_writer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitslam_reg_writer.sv
// ---------------------------------------------------------------------------
// bitslam_reg_writer
//
// Host-side writer for the bitslam register bus (the 7 bus bits above the
// clock bit). Register-write requests are queued in a small FIFO and each one
// is serialised into an address phase (bus_sel=0, payload {4'b0, voice, reg})
// followed by one data phase (bus_sel=1, payload = data). When nothing is
// queued the bus idles with bus_sel=0, rewriting the last address, which the
// chip tolerates.
//
// Optional feature (compile-time macro BITSLAM_ADDR_CACHE_EN):
//   When defined, a request whose {voice, reg} matches the address already
//   latched by the chip skips its address phase and goes straight to data.
//   The first request after reset always takes the address phase.
//
// Parameters:
//   DEPTH          FIFO entries; power of two, >= 2.
//
// Ports:
//   clk            system clock (same clock that drives the chip)
//   rst            asynchronous active-high reset
//   req_valid      write request presented
//   req_ready      FIFO can accept a request (= !full)
//   req_voice      voice select (0 = voice0, 1 = voice1)
//   req_reg        register select (0 = clock divider, 1 = LFSR tap mask)
//   req_data       6-bit register value
//   bus_sel        bus phase: 0 = address/idle, 1 = data
//   bus_addr_data  6-bit bus payload
//   fifo_level     number of queued entries
//   idle           FIFO empty and FSM in IDLE
// ---------------------------------------------------------------------------
module bitslam_reg_writer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_voice,
  input  logic                     req_reg,
  input  logic [5:0]               req_data,
  output logic                     bus_sel,
  output logic [5:0]               bus_addr_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // -------------------------------------------------------------------------
  // Request FIFO. Entries are {voice, reg, data[5:0]}.
  // The head is read combinationally so a pop can drive the bus on the very
  // next edge (address visible one cycle after acceptance). At this depth the
  // storage is a small register file rather than a block RAM.
  // -------------------------------------------------------------------------
  logic [7:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [7:0]       head;
  logic [1:0]       head_addr;
  logic [5:0]       head_data;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  // Ready depends only on the stored count, so a same-cycle pop never
  // re-opens a full FIFO.
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign head      = fifo_mem[rd_ptr_reg];
  assign head_addr = head[7:6];
  assign head_data = head[5:0];

  // Storage is not reset: contents are only observed through the count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {req_voice, req_reg, req_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign fifo_level = count_reg;

  // -------------------------------------------------------------------------
  // Bus sequencer
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic       bus_sel_reg, bus_sel_next;
  logic [5:0] bus_addr_data_reg, bus_addr_data_next;
  logic [5:0] data_reg, data_next;
  logic [1:0] last_addr_reg, last_addr_next;
  logic       launch;
  logic       cache_hit;

`ifdef BITSLAM_ADDR_CACHE_EN
  logic last_addr_valid_reg, last_addr_valid_next;

  // The chip's address latch already holds last_addr_reg once any address
  // phase has been issued, so a matching request can go straight to data.
  assign cache_hit = last_addr_valid_reg && (head_addr == last_addr_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr_valid_reg <= 1'b0;
    end else begin
      last_addr_valid_reg <= last_addr_valid_next;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_next         = state_reg;
    bus_sel_next       = bus_sel_reg;
    bus_addr_data_next = bus_addr_data_reg;
    data_next          = data_reg;
    last_addr_next     = last_addr_reg;
    launch             = 1'b0;
    pop                = 1'b0;
`ifdef BITSLAM_ADDR_CACHE_EN
    last_addr_valid_next = last_addr_valid_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        // Empty: bus keeps rewriting the current address.
        if (!empty) begin
          launch = 1'b1;
        end
      end
      ST_ADDR: begin
        state_next         = ST_DATA;
        bus_sel_next       = 1'b1;
        bus_addr_data_next = data_reg;
      end
      ST_DATA: begin
        if (!empty) begin
          launch = 1'b1;
        end else begin
          state_next         = ST_IDLE;
          bus_sel_next       = 1'b0;
          bus_addr_data_next = {4'b0000, last_addr_reg};
        end
      end
      default: begin
        state_next         = ST_IDLE;
        bus_sel_next       = 1'b0;
        bus_addr_data_next = {4'b0000, last_addr_reg};
      end
    endcase

    // Start the head request: either its address phase, or (address already
    // latched in the chip) its data phase directly.
    if (launch) begin
      pop            = 1'b1;
      last_addr_next = head_addr;
      if (cache_hit) begin
        state_next         = ST_DATA;
        bus_sel_next       = 1'b1;
        bus_addr_data_next = head_data;
      end else begin
        state_next         = ST_ADDR;
        bus_sel_next       = 1'b0;
        bus_addr_data_next = {4'b0000, head_addr};
        data_next          = head_data;
`ifdef BITSLAM_ADDR_CACHE_EN
        last_addr_valid_next = 1'b1;
`endif
      end
    end
  end

  // Reset clears the bus immediately so no data phase can follow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      bus_sel_reg       <= 1'b0;
      bus_addr_data_reg <= '0;
      data_reg          <= '0;
      last_addr_reg     <= 2'b00;
    end else begin
      state_reg         <= state_next;
      bus_sel_reg       <= bus_sel_next;
      bus_addr_data_reg <= bus_addr_data_next;
      data_reg          <= data_next;
      last_addr_reg     <= last_addr_next;
    end
  end

  assign bus_sel       = bus_sel_reg;
  assign bus_addr_data = bus_addr_data_reg;
  assign idle          = (state_reg == ST_IDLE) && empty;

endmodule

// File: tb/tb_bitslam_reg_writer.sv
// ---------------------------------------------------------------------------
// tb_bitslam_reg_writer
//
// Directed bench for bitslam_reg_writer. Accepted requests are pushed to a
// scoreboard queue; a chip model on the falling edge latches the address on
// bus_sel=0 and, on each data phase, pops the queue and checks the data and
// the address latched at that moment. Directed steps check cycle-exact bus,
// level and ready values. Define BITSLAM_ADDR_CACHE_EN for both files to
// exercise the address-skip build.
// ---------------------------------------------------------------------------
module tb_bitslam_reg_writer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_voice;
  logic       req_reg;
  logic [5:0] req_data;
  logic       bus_sel;
  logic [5:0] bus_addr_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic       idle;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic [1:0] chip_addr = 2'b00;
  logic       prev_sel  = 1'b0;

  always #5 clk = ~clk;

  bitslam_reg_writer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_voice     (req_voice),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .bus_sel       (bus_sel),
    .bus_addr_data (bus_addr_data),
    .fifo_level    (fifo_level),
    .idle          (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Chip model: samples the bus on the falling edge.
  always @(negedge clk) begin
    logic [7:0] exp_e;
    if (rst) begin
      chip_addr = 2'b00;
      prev_sel  = 1'b0;
    end else if (!bus_sel) begin
      chk("addr_hi_zero", {28'd0, bus_addr_data[5:2]}, 32'd0);
      chip_addr = bus_addr_data[1:0];
      prev_sel  = 1'b0;
    end else begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_data observed=%0h expected=none", bus_addr_data);
      end
      if (sb.size() != 0) begin
        exp_e = sb.pop_front();
        chk("data_value", {26'd0, bus_addr_data}, {26'd0, exp_e[5:0]});
        chk("data_addr", {30'd0, chip_addr}, {30'd0, exp_e[7:6]});
        $display("txn voice=%0d reg=%0d data=%02h", chip_addr[1], chip_addr[0], bus_addr_data);
      end
`ifndef BITSLAM_ADDR_CACHE_EN
      chk("no_back_to_back_sel", {31'd0, prev_sel}, 32'd0);
`endif
      prev_sel = 1'b1;
    end
  end

  // One clock: acceptance decided before the edge, checks run 1 after it.
  task automatic step(output logic acc);
    @(negedge clk);
    acc = req_valid && req_ready;
    @(posedge clk);
    #1;
    if (acc) sb.push_back({req_voice, req_reg, req_data});
  endtask

  task automatic push(input logic v, input logic r, input logic [5:0] d);
    logic acc;
    int n;
    req_voice = v;
    req_reg   = r;
    req_data  = d;
    req_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      step(acc);
      n++;
    end
    chk("push_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    logic a;
    int n;
    req_valid = 1'b0;
    n = 0;
    while (!(idle && sb.size() == 0) && n < 200) begin
      step(a);
      n++;
    end
    chk("drain_done", {31'd0, (idle && sb.size() == 0)}, 32'd1);
    step(a);
  endtask

  initial begin
    logic acc;
    int idx;
    logic [2:0] lvl_exp [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd3};
    logic       rdy_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef BITSLAM_ADDR_CACHE_EN
    logic       sel_exp [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [5:0] bad_exp [8] = '{6'h00, 6'h03, 6'h01, 6'h02, 6'h03, 6'h03, 6'h03, 6'h03};
`else
    logic       sel_exp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [5:0] bad_exp [8] = '{6'h00, 6'h03, 6'h01, 6'h03, 6'h02, 6'h03, 6'h03, 6'h03};
`endif
    logic [7:0] burst [10];

    for (int i = 0; i < 10; i++) begin
      burst[i] = {i[1:0], 6'(i * 5 + 1)};
    end

    rst = 1'b1;
    req_valid = 1'b0;
    req_voice = 1'b0;
    req_reg   = 1'b0;
    req_data  = 6'h00;

    // Reset state
    #3;
    chk("rst_bus_sel", {31'd0, bus_sel}, 32'd0);
    chk("rst_bus_addr_data", {26'd0, bus_addr_data}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(acc);

    // Single request: address for one cycle, data for one, then idle address
    push(1'b1, 1'b0, 6'h2A);
    req_valid = 1'b0;
    chk("t1_level_after_push", {29'd0, fifo_level}, 32'd1);
    chk("t1_not_idle", {31'd0, idle}, 32'd0);
    chk("t1_e0_sel", {31'd0, bus_sel}, 32'd0);
    chk("t1_e0_bus", {26'd0, bus_addr_data}, 32'h00);
    step(acc);
    chk("t1_e1_sel", {31'd0, bus_sel}, 32'd0);
    chk("t1_e1_bus", {26'd0, bus_addr_data}, 32'h02);
    chk("t1_e1_level", {29'd0, fifo_level}, 32'd0);
    step(acc);
    chk("t1_e2_sel", {31'd0, bus_sel}, 32'd1);
    chk("t1_e2_bus", {26'd0, bus_addr_data}, 32'h2A);
    step(acc);
    chk("t1_e3_sel", {31'd0, bus_sel}, 32'd0);
    chk("t1_e3_bus", {26'd0, bus_addr_data}, 32'h02);
    chk("t1_e3_idle", {31'd0, idle}, 32'd1);
    step(acc);
    chk("t1_e4_bus", {26'd0, bus_addr_data}, 32'h02);

    // Burst with req_valid held: fills to DEPTH, push+pop at level 2,
    // full with a pop keeps ready low for that cycle
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      req_voice = burst[idx][7];
      req_reg   = burst[idx][6];
      req_data  = burst[idx][5:0];
      req_valid = 1'b1;
      step(acc);
      if (acc) idx++;
      chk("t2_level", {29'd0, fifo_level}, {29'd0, lvl_exp[k]});
      chk("t2_ready", {31'd0, req_ready}, {31'd0, rdy_exp[k]});
      if (k == 7) chk("t2_full_no_accept", {31'd0, acc}, 32'd0);
    end
    while (idx < 10) begin
      push(burst[idx][7], burst[idx][6], burst[idx][5:0]);
      idx++;
    end
    drain();

    // Reset during the data phase of A with B and C queued
    push(1'b0, 1'b0, 6'h11);
    push(1'b0, 1'b1, 6'h22);
    push(1'b1, 1'b0, 6'h33);
    req_valid = 1'b0;
    chk("t4_a_data_sel", {31'd0, bus_sel}, 32'd1);
    chk("t4_a_data_bus", {26'd0, bus_addr_data}, 32'h11);
    chk("t4_level_before", {29'd0, fifo_level}, 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("t4_rst_sel", {31'd0, bus_sel}, 32'd0);
    chk("t4_rst_bus", {26'd0, bus_addr_data}, 32'd0);
    chk("t4_rst_level", {29'd0, fifo_level}, 32'd0);
    chk("t4_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("t4_rst_idle", {31'd0, idle}, 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(acc);
      chk("t4_quiet_sel", {31'd0, bus_sel}, 32'd0);
      chk("t4_quiet_level", {29'd0, fifo_level}, 32'd0);
    end

    // Trickle 10 requests, one per 3 cycles: pointers wrap, level stays <= 1
    for (int i = 0; i < 10; i++) begin
      push(i[0], i[1], 6'(i * 7 + 3));
      req_valid = 1'b0;
      chk("t5_level_pushed", {29'd0, fifo_level}, 32'd1);
      step(acc);
      chk("t5_level_popped", {29'd0, fifo_level}, 32'd0);
      step(acc);
    end
    drain();

    // Three requests to address 2'b11 right after reset
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(acc);
    rst = 1'b0;
    step(acc);
    for (int k = 0; k < 8; k++) begin
      if (k < 3) begin
        req_voice = 1'b1;
        req_reg   = 1'b1;
        req_data  = 6'(k + 1);
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      step(acc);
      if (k < 3) chk("t6_accept", {31'd0, acc}, 32'd1);
      if (k >= 1) begin
        chk("t6_sel", {31'd0, bus_sel}, {31'd0, sel_exp[k]});
        chk("t6_bus", {26'd0, bus_addr_data}, {26'd0, bad_exp[k]});
      end
    end
    drain();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
